// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: schedule sequencer for a clock divider.
//
// Holds an NSTAGE-entry table of {rate select, duration}. On start it walks the
// table from entry 0, driving each entry's rate select to the divider and holding
// it for 'dur' rising edges of the returned divided clock. A stage with dur=0
// lasts exactly one clk cycle with the divider disabled. After the last entry it
// either wraps to entry 0 (loop=1) or returns to idle with a one-cycle done pulse.
//
// Ports:
//   clk      in   system clock, all logic on posedge
//   rst      in   synchronous active-high reset
//   start    in   level request to run the schedule (ignored while running)
//   stop     in   level abort request (wins over start)
//   loop     in   1 = wrap after last stage, 0 = finish after last stage
//   wr_en    in   table write strobe (accepted only while idle)
//   wr_addr  in   table entry index
//   wr_sel   in   rate code to store
//   wr_dur   in   stage length in div_clk rising edges
//   div_clk  in   divided clock, already registered in the clk domain
//   sel      out  rate select to the divider
//   en       out  divider enable
//   stage    out  current table index
//   busy     out  high while running
//   done     out  one-cycle pulse on normal completion
//   wr_err   out  one-cycle pulse when a write is rejected
module div_seq_ctrl #(
    parameter int unsigned NSTAGE = 4,
    parameter int unsigned DURW   = 8,
    localparam int unsigned AW    = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            loop,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [1:0]      wr_sel,
    input  logic [DURW-1:0] wr_dur,
    input  logic            div_clk,
    output logic [1:0]      sel,
    output logic            en,
    output logic [AW-1:0]   stage,
    output logic            busy,
    output logic            done,
    output logic            wr_err
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   stage_q, stage_d;
    logic [DURW-1:0] cnt_q, cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic            en_q, en_d;
    logic            done_q, done_d;
    logic            wr_err_q, wr_err_d;
    logic            div_q;

    logic [1:0]      tbl_sel_q [NSTAGE];
    logic [DURW-1:0] tbl_dur_q [NSTAGE];

    logic            div_rise;
    logic            last_stage;
    logic            stage_end;
    logic [AW-1:0]   next_idx;
    logic [DURW-1:0] cnt_inc;
    logic [DURW-1:0] cur_dur;

    assign div_rise   = div_clk & ~div_q;
    assign last_stage = (stage_q == AW'(NSTAGE - 1));
    assign next_idx   = last_stage ? '0 : stage_q + AW'(1);
    assign cnt_inc    = cnt_q + DURW'(1);
    assign cur_dur    = tbl_dur_q[stage_q];

    // Table storage; writes are only accepted while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTAGE; i++) begin
                tbl_sel_q[i] <= '0;
                tbl_dur_q[i] <= '0;
            end
        end else if (state_q == StIdle && wr_en) begin
            tbl_sel_q[wr_addr] <= wr_sel;
            tbl_dur_q[wr_addr] <= wr_dur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            stage_q  <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            div_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
            div_q    <= div_clk;
        end
    end

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        en_d      = en_q;
        done_d    = 1'b0;
        wr_err_d  = 1'b0;
        stage_end = 1'b0;

        unique case (state_q)
            StIdle: begin
                en_d = 1'b0;
                if (start && !stop) begin
                    state_d = StRun;
                    stage_d = '0;
                    cnt_d   = '0;
                    sel_d   = tbl_sel_q[0];
                    en_d    = (tbl_dur_q[0] != '0);
                end
            end
            StRun: begin
                if (wr_en) begin
                    wr_err_d = 1'b1;
                end
                if (stop) begin
                    // Abort: stage and sel hold, any edge this cycle is dropped.
                    state_d = StIdle;
                    en_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    if (cur_dur == '0) begin
                        stage_end = 1'b1;
                    end else if (div_rise) begin
                        if (cnt_inc == cur_dur) begin
                            stage_end = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    if (stage_end) begin
                        cnt_d = '0;
                        if (last_stage && !loop) begin
                            state_d = StIdle;
                            en_d    = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            stage_d = next_idx;
                            sel_d   = tbl_sel_q[next_idx];
                            en_d    = (tbl_dur_q[next_idx] != '0);
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign sel    = sel_q;
    assign en     = en_q;
    assign stage  = stage_q;
    assign busy   = (state_q == StRun);
    assign done   = done_q;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: table-driven cycle vectors with a scoreboard queue.
// Expected output word layout: {sel[1:0], en, stage[1:0], busy, done, wr_err}.
module tb_div_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, loop, wr_en, div_clk;
    logic [1:0] wr_addr, wr_sel, sel, stage;
    logic [7:0] wr_dur;
    logic       en, busy, done, wr_err;

    always #5 clk = ~clk;

    div_seq_ctrl #(.NSTAGE(4), .DURW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .loop    (loop),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_sel  (wr_sel),
        .wr_dur  (wr_dur),
        .div_clk (div_clk),
        .sel     (sel),
        .en      (en),
        .stage   (stage),
        .busy    (busy),
        .done    (done),
        .wr_err  (wr_err)
    );

    typedef struct {
        logic       rst, start, stop, loop, wr_en;
        logic [1:0] wa, ws;
        logic [7:0] wd;
        logic       dc;
        logic [7:0] ex;
        string      nm;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] sb[$];
    string      nq[$];
    int         checks = 0;
    int         passed = 0;

    function automatic logic [7:0] mk(input logic [1:0] s, input logic e, input logic [1:0] st,
                                      input logic b, input logic d, input logic w);
        return {s, e, st, b, d, w};
    endfunction

    // Running stage with divider enabled and no pulses.
    function automatic logic [7:0] rn(input logic [1:0] s, input logic [1:0] st);
        return mk(s, 1'b1, st, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic add(input logic r, input logic st, input logic sp, input logic lp,
                       input logic we, input logic [1:0] wa, input logic [1:0] ws,
                       input logic [7:0] wd, input logic dc, input logic [7:0] ex,
                       input string nm);
        vec_t v;
        v.rst = r; v.start = st; v.stop = sp; v.loop = lp; v.wr_en = we;
        v.wa = wa; v.ws = ws; v.wd = wd; v.dc = dc; v.ex = ex; v.nm = nm;
        vq.push_back(v);
    endtask

    // One div_clk pulse: high cycle then low cycle. Pulses clear on the low cycle.
    task automatic pulse(input logic lp, input logic [7:0] ex, input string nm);
        add(1'b0, 1'b0, 1'b0, lp, 1'b0, 2'd0, 2'd0, 8'd0, 1'b1, ex, {nm, "_rise"});
        add(1'b0, 1'b0, 1'b0, lp, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, ex & 8'hFC, {nm, "_fall"});
    endtask

    task automatic apply(input vec_t v);
        logic [7:0] got, exp;
        string      nm;
        rst = v.rst; start = v.start; stop = v.stop; loop = v.loop; wr_en = v.wr_en;
        wr_addr = v.wa; wr_sel = v.ws; wr_dur = v.wd; div_clk = v.dc;
        sb.push_back(v.ex);
        nq.push_back(v.nm);
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        nm  = nq.pop_front();
        got = {sel, en, stage, busy, done, wr_err};
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got sel/en/stage/busy/done/wr_err=%b/%b/%b/%b/%b/%b want %b/%b/%b/%b/%b/%b",
                      nm, got[7:6], got[5], got[4:3], got[2], got[1], got[0],
                      exp[7:6], exp[5], exp[4:3], exp[2], exp[1], exp[0]);
    endtask

    task automatic run_all();
        while (vq.size() > 0) begin
            apply(vq.pop_front());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] idle0;
        idle0 = mk(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_sel = '0; wr_dur = '0; div_clk = 1'b0;

        // Reset, then load {(00,2),(01,1),(11,3),(10,1)} and run once with loop=0.
        add(1, 0, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, idle0, "reset0");
        add(1, 0, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, idle0, "reset1");
        add(0, 0, 0, 0, 1, 2'd0, 2'b00, 8'd2, 0, idle0, "wr0");
        add(0, 0, 0, 0, 1, 2'd1, 2'b01, 8'd1, 0, idle0, "wr1");
        add(0, 0, 0, 0, 1, 2'd2, 2'b11, 8'd3, 0, idle0, "wr2");
        add(0, 0, 0, 0, 1, 2'd3, 2'b10, 8'd1, 0, idle0, "wr3");
        add(0, 1, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, rn(2'b00, 2'd0), "start");
        add(0, 0, 0, 0, 0, 2'd0, 2'd0, 8'd0, 1, rn(2'b00, 2'd0), "s0_e1");
        // Write while busy must be rejected with a wr_err pulse.
        add(0, 0, 0, 0, 1, 2'd0, 2'b11, 8'd5, 0, mk(2'b00, 1, 2'd0, 1, 0, 1), "wr_busy");
        pulse(0, rn(2'b01, 2'd1), "s0_end");
        pulse(0, rn(2'b11, 2'd2), "s1_end");
        pulse(0, rn(2'b11, 2'd2), "s2_e1");
        pulse(0, rn(2'b11, 2'd2), "s2_e2");
        pulse(0, rn(2'b10, 2'd3), "s2_end");
        pulse(0, mk(2'b10, 0, 2'd3, 0, 1, 0), "done");

        // Loop run doubles as readback: stage 0 must still be (00,2).
        add(0, 1, 0, 1, 0, 2'd0, 2'd0, 8'd0, 0, rn(2'b00, 2'd0), "lp_start");
        pulse(1, rn(2'b00, 2'd0), "lp_s0_e1");
        pulse(1, rn(2'b01, 2'd1), "lp_s0_end");
        pulse(1, rn(2'b11, 2'd2), "lp_s1_end");
        pulse(1, rn(2'b11, 2'd2), "lp_s2_e1");
        pulse(1, rn(2'b11, 2'd2), "lp_s2_e2");
        pulse(1, rn(2'b10, 2'd3), "lp_s2_end");
        pulse(1, rn(2'b00, 2'd0), "lp_wrap");
        pulse(0, rn(2'b00, 2'd0), "nl_s0_e1");
        pulse(0, rn(2'b01, 2'd1), "nl_s0_end");
        pulse(0, rn(2'b11, 2'd2), "nl_s1_end");
        pulse(0, rn(2'b11, 2'd2), "nl_s2_e1");
        pulse(0, rn(2'b11, 2'd2), "nl_s2_e2");
        pulse(0, rn(2'b10, 2'd3), "nl_s2_end");
        pulse(0, mk(2'b10, 0, 2'd3, 0, 1, 0), "nl_done");

        for (int i = 0; vq.size() > 0; i++) begin
            apply(vq.pop_front());
        end

        // Stop together with a div_clk edge mid-stage-2, then restart.
        add(0, 1, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, rn(2'b00, 2'd0), "sp_start");
        pulse(0, rn(2'b00, 2'd0), "sp_s0_e1");
        pulse(0, rn(2'b01, 2'd1), "sp_s0_end");
        pulse(0, rn(2'b11, 2'd2), "sp_s1_end");
        add(0, 0, 1, 0, 0, 2'd0, 2'd0, 8'd0, 1, mk(2'b11, 0, 2'd2, 0, 0, 0), "stop_edge");
        add(0, 0, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, mk(2'b11, 0, 2'd2, 0, 0, 0), "stop_hold");
        add(0, 1, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, rn(2'b00, 2'd0), "restart");
        // start+stop while running aborts.
        add(0, 1, 1, 0, 0, 2'd0, 2'd0, 8'd0, 0, mk(2'b00, 0, 2'd0, 0, 0, 0), "run_ststop");
        // start+stop while idle stays idle.
        add(0, 1, 1, 0, 0, 2'd0, 2'd0, 8'd0, 0, mk(2'b00, 0, 2'd0, 0, 0, 0), "idle_ststop");
        run_all();

        // Entry 1 with dur=0 lasts exactly one cycle with en=0.
        add(0, 0, 0, 0, 1, 2'd1, 2'b01, 8'd0, 0, mk(2'b00, 0, 2'd0, 0, 0, 0), "wr1_zero");
        add(0, 1, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, rn(2'b00, 2'd0), "z_start");
        pulse(0, rn(2'b00, 2'd0), "z_s0_e1");
        add(0, 0, 0, 0, 0, 2'd0, 2'd0, 8'd0, 1, mk(2'b01, 0, 2'd1, 1, 0, 0), "z_s1_enter");
        add(0, 0, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, rn(2'b11, 2'd2), "z_s2_enter");
        pulse(0, rn(2'b11, 2'd2), "z_s2_e1");
        // Reset in stage 2, colliding with start and a write: reset wins.
        add(1, 1, 0, 0, 1, 2'd0, 2'b11, 8'd7, 0, idle0, "rst_run");
        add(0, 1, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, mk(2'b00, 0, 2'd0, 1, 0, 0), "zt_s0");
        add(0, 0, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, mk(2'b00, 0, 2'd1, 1, 0, 0), "zt_s1");
        add(0, 0, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, mk(2'b00, 0, 2'd2, 1, 0, 0), "zt_s2");
        add(0, 0, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, mk(2'b00, 0, 2'd3, 1, 0, 0), "zt_s3");
        add(0, 0, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, mk(2'b00, 0, 2'd3, 0, 1, 0), "zt_done");
        add(0, 0, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, mk(2'b00, 0, 2'd3, 0, 0, 0), "zt_idle");
        run_all();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
